// File: rtl/camera_frame_gen.sv
// ============================================================================
//  Module   : camera_frame_gen
//  Brief    : Sensor-side camera conduit transmitter (fval/lval/pixdata),
//             one snapshot frame per falling edge of trigger_n.
//             Optional: CAMERA_FRAME_GEN_CONTINUOUS_EN adds free-running mode.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module camera_frame_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int FV_TO_LV = 4,
    parameter int LV_TO_FV = 4,
    parameter int V_GAP    = 32,
    parameter int DATA_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
`ifdef CAMERA_FRAME_GEN_CONTINUOUS_EN
    input  logic              continuous,
`endif
    input  logic              trigger_n,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] const_value,
    output logic              fval,
    output logic              lval,
    output logic [DATA_W-1:0] pixdata,
    output logic              busy,
    output logic              frame_done
);

    localparam int C_CNT_A   = (FV_TO_LV > H_BLANK) ? FV_TO_LV : H_BLANK;
    localparam int C_CNT_B   = (LV_TO_FV > V_GAP) ? LV_TO_FV : V_GAP;
    localparam int C_CNT_MAX = (C_CNT_A > C_CNT_B) ? C_CNT_A : C_CNT_B;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam int C_COL_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int C_ROW_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRE    = 3'd1,
        S_LINE   = 3'd2,
        S_HBLANK = 3'd3,
        S_POST   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t               r_state,   w_nxt_state;
    logic [C_CNT_W-1:0]   r_cnt,     w_nxt_cnt;
    logic [C_COL_W-1:0]   r_col,     w_nxt_col;
    logic [C_ROW_W-1:0]   r_row,     w_nxt_row;
    logic                 r_trig_q;
    logic [1:0]           r_pat;
    logic [DATA_W-1:0]    r_cval;
    logic                 w_edge;
    logic                 w_start;
    logic                 w_done;
    logic                 w_repeat;
    logic [31:0]          w_col_x;
    logic [31:0]          w_row_x;
    logic [DATA_W-1:0]    w_pix;

`ifdef CAMERA_FRAME_GEN_CONTINUOUS_EN
    assign w_repeat = continuous;
`else
    assign w_repeat = 1'b0;
`endif

    assign w_edge = r_trig_q & ~trigger_n;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_col   = r_col;
        w_nxt_row   = r_row;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_nxt_state = S_PRE;
                    w_nxt_cnt   = '0;
                    w_nxt_col   = '0;
                    w_nxt_row   = '0;
                    w_start     = 1'b1;
                end
            end
            S_PRE: begin
                if (r_cnt == C_CNT_W'(FV_TO_LV - 1)) begin
                    w_nxt_state = S_LINE;
                    w_nxt_cnt   = '0;
                    w_nxt_col   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            S_LINE: begin
                if (r_col == C_COL_W'(H_ACTIVE - 1)) begin
                    w_nxt_state = (r_row == C_ROW_W'(V_ACTIVE - 1)) ? S_POST : S_HBLANK;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_col = r_col + 1'b1;
                end
            end
            S_HBLANK: begin
                if (r_cnt == C_CNT_W'(H_BLANK - 1)) begin
                    w_nxt_state = S_LINE;
                    w_nxt_cnt   = '0;
                    w_nxt_col   = '0;
                    w_nxt_row   = r_row + 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            S_POST: begin
                if (r_cnt == C_CNT_W'(LV_TO_FV - 1)) begin
                    w_nxt_state = S_GAP;
                    w_nxt_cnt   = '0;
                    w_done      = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == C_CNT_W'(V_GAP - 1)) begin
                    w_nxt_cnt = '0;
                    if (w_repeat) begin
                        w_nxt_state = S_PRE;
                        w_nxt_col   = '0;
                        w_nxt_row   = '0;
                        w_start     = 1'b1;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // Pixel is generated from next-cycle coordinates so it lines up with registered lval.
    assign w_col_x = 32'(w_nxt_col);
    assign w_row_x = 32'(w_nxt_row);

    always_comb begin
        w_pix = '0;
        if (w_nxt_state == S_LINE) begin
            case (r_pat)
                2'd0:    w_pix = DATA_W'(w_row_x + w_col_x);
                2'd1:    w_pix = w_col_x[4] ? {DATA_W{1'b1}} : '0;
                2'd2:    w_pix = (w_row_x[3] ^ w_col_x[3]) ? {DATA_W{1'b1}} : '0;
                default: w_pix = r_cval;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_trig_q   <= 1'b1;
            r_pat      <= '0;
            r_cval     <= '0;
            fval       <= 1'b0;
            lval       <= 1'b0;
            pixdata    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_col      <= w_nxt_col;
            r_row      <= w_nxt_row;
            r_trig_q   <= trigger_n;
            if (w_start) begin
                r_pat  <= pattern_sel;
                r_cval <= const_value;
            end
            fval       <= (w_nxt_state == S_PRE) || (w_nxt_state == S_LINE) ||
                          (w_nxt_state == S_HBLANK) || (w_nxt_state == S_POST);
            lval       <= (w_nxt_state == S_LINE);
            pixdata    <= w_pix;
            busy       <= (w_nxt_state != S_IDLE);
            frame_done <= w_done;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_camera_frame_gen.sv
// ============================================================================
//  Module   : tb_camera_frame_gen
//  Brief    : Scoreboard bench for camera_frame_gen on a 4x2 frame.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_camera_frame_gen;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int HB = 2;
    localparam int FV = 1;
    localparam int LV = 1;
    localparam int VG = 3;
    localparam int DW = 12;
    localparam int FEND = FV + V * H + (V - 1) * HB + LV;

    typedef struct packed {
        logic          fval;
        logic          lval;
        logic [DW-1:0] pix;
        logic          busy;
        logic          done;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          trigger_n;
    logic [1:0]    pattern_sel;
    logic [DW-1:0] const_value;
    logic          fval;
    logic          lval;
    logic [DW-1:0] pixdata;
    logic          busy;
    logic          frame_done;
`ifdef CAMERA_FRAME_GEN_CONTINUOUS_EN
    logic          continuous;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    camera_frame_gen #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .H_BLANK  (HB),
        .FV_TO_LV (FV),
        .LV_TO_FV (LV),
        .V_GAP    (VG),
        .DATA_W   (DW)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
`ifdef CAMERA_FRAME_GEN_CONTINUOUS_EN
        .continuous  (continuous),
`endif
        .trigger_n   (trigger_n),
        .pattern_sel (pattern_sel),
        .const_value (const_value),
        .fval        (fval),
        .lval        (lval),
        .pixdata     (pixdata),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    task automatic check_eq(input string tag, input int k, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix_model(input logic [1:0] pat, input logic [DW-1:0] cv,
                                                input int r, input int c);
        case (pat)
            2'd0:    return DW'(r + c);
            2'd1:    return ((c >> 4) & 1) != 0 ? {DW{1'b1}} : '0;
            2'd2:    return (((r >> 3) ^ (c >> 3)) & 1) != 0 ? {DW{1'b1}} : '0;
            default: return cv;
        endcase
    endfunction

    // Expected outputs k cycles after the trigger edge of an undisturbed frame.
    function automatic exp_t frame_model(input int k, input logic [1:0] pat,
                                         input logic [DW-1:0] cv);
        exp_t e;
        e = '0;
        e.fval = (k >= 1) && (k <= FEND);
        e.busy = (k >= 1) && (k <= FEND + VG);
        e.done = (k == FEND + 1);
        for (int r = 0; r < V; r++) begin
            int s;
            s = 1 + FV + r * (H + HB);
            if (k >= s && k < s + H) begin
                e.lval = 1'b1;
                e.pix  = pix_model(pat, cv, r, k - s);
            end
        end
        return e;
    endfunction

    // Edge is applied in cycle 0; cycle k is sampled 1 time unit after the k-th posedge.
    task automatic run_frame(input string tag, input logic [1:0] pat, input logic [DW-1:0] cv,
                             input int n_cyc, input int release_at, input int retrig_at,
                             input int cval_chg_at, input int reset_at, input int period,
                             input int cont_off_at);
        exp_t e;
        pattern_sel = pat;
        const_value = cv;
        trigger_n   = 1'b0;
        for (int k = 1; k <= n_cyc; k++) begin
            if (reset_at > 0 && k > reset_at)
                e = '0;
            else if (period > 0 && k > period)
                e = frame_model(k - period, pat, cv);
            else
                e = frame_model(k, pat, cv);
            sb.push_back(e);
        end
        for (int k = 1; k <= n_cyc; k++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_eq({tag, ".fval"}, k, 32'(fval), 32'(e.fval));
            check_eq({tag, ".lval"}, k, 32'(lval), 32'(e.lval));
            check_eq({tag, ".pix"},  k, 32'(pixdata), 32'(e.pix));
            check_eq({tag, ".busy"}, k, 32'(busy), 32'(e.busy));
            check_eq({tag, ".done"}, k, 32'(frame_done), 32'(e.done));
            if (k == release_at)      trigger_n = 1'b1;
            if (k == retrig_at - 1)   trigger_n = 1'b1;
            if (k == retrig_at)       trigger_n = 1'b0;
            if (k == cval_chg_at)     const_value = 12'h123;
            if (k == reset_at)        reset = 1'b1;
`ifdef CAMERA_FRAME_GEN_CONTINUOUS_EN
            if (k == cont_off_at)     continuous = 1'b0;
`endif
        end
        check_eq({tag, ".sb_empty"}, 0, 32'(sb.size()), 32'd0);
        reset     = 1'b0;
        trigger_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        trigger_n   = 1'b1;
        pattern_sel = 2'd0;
        const_value = '0;
`ifdef CAMERA_FRAME_GEN_CONTINUOUS_EN
        continuous  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.fval", 0, 32'(fval), 32'd0);
        check_eq("rst.lval", 0, 32'(lval), 32'd0);
        check_eq("rst.pix",  0, 32'(pixdata), 32'd0);
        check_eq("rst.busy", 0, 32'(busy), 32'd0);
        check_eq("rst.done", 0, 32'(frame_done), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Ramp frame followed by idle cycles proving no extra frame.
        run_frame("ramp", 2'd0, 12'h000, 20, 2, -10, -1, -1, 0, -1);
        // Second falling edge in mid-frame must be dropped.
        run_frame("retrig", 2'd0, 12'h000, 20, -1, 6, -1, -1, 0, -1);
        // Constant value is latched at frame start.
        run_frame("const", 2'd3, 12'hABC, 18, 2, -10, 4, -1, 0, -1);
        // Reset in the middle of the first line.
        run_frame("rstmid", 2'd0, 12'h000, 8, 3, -10, -1, 3, 0, -1);
        run_frame("after_rst", 2'd1, 12'h000, 17, 2, -10, -1, -1, 0, -1);
        // Trigger held low for 40 cycles produces a single frame.
        run_frame("held", 2'd2, 12'h000, 40, 40, -10, -1, -1, 0, -1);
        run_frame("held2", 2'd0, 12'h000, 17, 2, -10, -1, -1, 0, -1);
`ifdef CAMERA_FRAME_GEN_CONTINUOUS_EN
        continuous = 1'b1;
        run_frame("cont", 2'd0, 12'h000, 36, 2, -10, -1, -1, FEND + VG, 20);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
